// File: rtl/div_core.sv
`default_nettype none
// ============================================================================
// div_core : multi-cycle RV32M divider (DIV/DIVU/REM/REMU), radix-2 restoring
// Revision : 1.0
// ============================================================================
module div_core (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        div_start_i,
  input  logic [1:0]  div_op_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  output logic        div_res_ready_o,
  output logic [31:0] div_result_o,
  output logic        div_busy_o
);

  localparam int CPU_WIDTH = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nx;

  logic                 r_ready;
  logic                 r_busy;
  logic [CPU_WIDTH-1:0] r_result;
  logic [1:0]           r_op;
  logic [CPU_WIDTH-1:0] r_dvd;
  logic [CPU_WIDTH-1:0] r_dvs;
  logic [CPU_WIDTH-1:0] r_rem;
  logic [5:0]           r_cnt;
  logic                 r_q_neg;
  logic                 r_r_neg;

  logic                 w_signed;
  logic                 w_s1;
  logic                 w_s2;
  logic [CPU_WIDTH-1:0] w_abs_a;
  logic [CPU_WIDTH-1:0] w_abs_b;
  logic                 w_div0;
  logic                 w_ovf;
  logic                 w_special;
  logic [CPU_WIDTH-1:0] w_special_res;
  logic [CPU_WIDTH:0]   w_rem_sh;
  logic [CPU_WIDTH:0]   w_rem_diff;
  logic                 w_ge;
  logic [CPU_WIDTH-1:0] w_rem_nx;
  logic [CPU_WIDTH-1:0] w_dvd_nx;
  logic                 w_last;
  logic [CPU_WIDTH-1:0] w_q_final;
  logic [CPU_WIDTH-1:0] w_r_final;
  logic [CPU_WIDTH-1:0] w_final;

  // Operand conditioning in IDLE: DIV/REM have op[0]=0.
  assign w_signed  = ~div_op_i[0];
  assign w_s1      = w_signed & dividend_i[CPU_WIDTH-1];
  assign w_s2      = w_signed & divisor_i[CPU_WIDTH-1];
  assign w_abs_a   = w_s1 ? (~dividend_i + 32'd1) : dividend_i;
  assign w_abs_b   = w_s2 ? (~divisor_i + 32'd1) : divisor_i;
  assign w_div0    = (divisor_i == 32'd0);
  assign w_ovf     = w_signed && (dividend_i == 32'h8000_0000) && (divisor_i == 32'hFFFF_FFFF);
  assign w_special = w_div0 | w_ovf;
  assign w_special_res = w_div0 ? (div_op_i[1] ? dividend_i : 32'hFFFF_FFFF)
                                : (div_op_i[1] ? 32'd0      : 32'h8000_0000);

  // Remainder stays below the divisor, so the 33-bit difference's MSB is the borrow.
  assign w_rem_sh   = {r_rem, r_dvd[CPU_WIDTH-1]};
  assign w_rem_diff = w_rem_sh - {1'b0, r_dvs};
  assign w_ge       = ~w_rem_diff[CPU_WIDTH];
  assign w_rem_nx   = w_ge ? w_rem_diff[CPU_WIDTH-1:0] : w_rem_sh[CPU_WIDTH-1:0];
  assign w_dvd_nx   = {r_dvd[CPU_WIDTH-2:0], w_ge};
  assign w_last     = (r_cnt == 6'd31);
  assign w_q_final  = r_q_neg ? (~w_dvd_nx + 32'd1) : w_dvd_nx;
  assign w_r_final  = r_r_neg ? (~w_rem_nx + 32'd1) : w_rem_nx;
  assign w_final    = r_op[1] ? w_r_final : w_q_final;

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE: if (div_start_i) w_state_nx = w_special ? S_DONE : S_CALC;
      S_CALC: begin
        if (!div_start_i)  w_state_nx = S_IDLE;
        else if (w_last)   w_state_nx = S_DONE;
      end
      S_DONE:  w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_ready <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_ready <= (w_state_nx == S_DONE);
      r_busy  <= (w_state_nx == S_CALC);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_result <= '0;
      r_op     <= '0;
      r_dvd    <= '0;
      r_dvs    <= '0;
      r_rem    <= '0;
      r_cnt    <= '0;
      r_q_neg  <= 1'b0;
      r_r_neg  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (div_start_i) begin
            if (w_special) begin
              r_result <= w_special_res;
            end else begin
              r_op    <= div_op_i;
              r_dvd   <= w_abs_a;
              r_dvs   <= w_abs_b;
              r_q_neg <= w_s1 ^ w_s2;
              r_r_neg <= w_s1;
              r_rem   <= '0;
              r_cnt   <= '0;
            end
          end
        end
        S_CALC: begin
          // A dropped start is a flush: leave the result untouched.
          if (div_start_i) begin
            r_rem <= w_rem_nx;
            r_dvd <= w_dvd_nx;
            r_cnt <= r_cnt + 6'd1;
            if (w_last) r_result <= w_final;
          end
        end
        default: ;
      endcase
    end
  end

  assign div_res_ready_o = r_ready;
  assign div_result_o    = r_result;
  assign div_busy_o      = r_busy;

endmodule
`default_nettype wire
